// File: rtl/aes_key_schedule_unit.sv
// aes_key_schedule_unit: iterative AES key expansion into a round-key table with combinational read port
module aes_key_schedule_unit #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [KEY_BITS-1:0] cipher_key_i,
  output logic                busy_o,
  output logic                ready_o,
  output logic [3:0]          keys_avail_o,
  input  logic [3:0]          rd_index_i,
  output logic [127:0]        rd_key_o
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  avail_q, avail_d;
  logic [31:0] w_q [NW];
  logic        load;
  logic [31:0] t, t_mix, word_d;
  logic [5:0]  base;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] j);
    return j <= 4'd8 ? 8'(8'h01 << (j - 4'd1)) : j == 4'd9 ? 8'h1b : 8'h36;
  endfunction

  // Next schedule word from the two table taps, plus FSM/counter/progress next state
  always_comb begin
    t       = w_q[cnt_q - 6'd1];
    t_mix   = (cnt_q % 6'(NK) == 6'd0) ? sub_word({t[23:0], t[31:24]}) ^ {rcon(4'(cnt_q / 6'(NK))), 24'h0} :
              (NK == 8 && cnt_q[1:0] == 2'd0) ? sub_word(t) : t;
    word_d  = w_q[cnt_q - 6'(NK)] ^ t_mix;
    state_d = state_q;
    cnt_d   = cnt_q;
    avail_d = avail_q;
    load    = 1'b0;
    if (state_q != EXPAND && start_i) begin
      load    = 1'b1;
      cnt_d   = 6'(NK);
      avail_d = 4'(NK / 4);
      state_d = EXPAND;
    end else if (state_q == EXPAND) begin
      cnt_d   = cnt_q + 6'd1;
      avail_d = cnt_q[1:0] == 2'd3 ? cnt_q[5:2] + 4'd1 : avail_q;
      state_d = cnt_q == 6'(NW - 1) ? READY : EXPAND;
    end
  end

  // State, counters and word table; reset wipes the whole table
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      avail_q <= '0;
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      avail_q <= avail_d;
      if (load) for (int k = 0; k < NK; k++) w_q[k] <= cipher_key_i[KEY_BITS-1-32*k -: 32];
      else if (state_q == EXPAND) w_q[cnt_q] <= word_d;
    end
  end

  assign base         = {rd_index_i, 2'b00};
  assign busy_o       = state_q == EXPAND;
  assign ready_o      = state_q == READY;
  assign keys_avail_o = avail_q;
  assign rd_key_o     = int'(rd_index_i) > NR ? 128'h0 :
                        {w_q[base], w_q[{rd_index_i, 2'd1}], w_q[{rd_index_i, 2'd2}], w_q[{rd_index_i, 2'd3}]};
endmodule

// File: tb/tb_aes_key_schedule_unit.sv
// tb_aes_key_schedule_unit: FIPS-197 vectors plus random keys checked against a textbook expansion model
module tb_aes_key_schedule_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst_n;
  logic         start [3];
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [3:0]   rd_idx [3];
  logic         busy [3];
  logic         ready [3];
  logic [3:0]   avail [3];
  logic [127:0] rdkey [3];
  int n_cmp = 0, n_bad = 0;
  logic [7:0]  sbox_t [256];
  logic [31:0] ref_w [60];

  localparam logic [255:0] K2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_key_schedule_unit #(.KEY_BITS(128)) u128 (.clk_i(clk), .rst_ni(rst_n), .start_i(start[0]),
    .cipher_key_i(key128), .busy_o(busy[0]), .ready_o(ready[0]), .keys_avail_o(avail[0]),
    .rd_index_i(rd_idx[0]), .rd_key_o(rdkey[0]));
  aes_key_schedule_unit #(.KEY_BITS(192)) u192 (.clk_i(clk), .rst_ni(rst_n), .start_i(start[1]),
    .cipher_key_i(key192), .busy_o(busy[1]), .ready_o(ready[1]), .keys_avail_o(avail[1]),
    .rd_index_i(rd_idx[1]), .rd_key_o(rdkey[1]));
  aes_key_schedule_unit #(.KEY_BITS(256)) u256 (.clk_i(clk), .rst_ni(rst_n), .start_i(start[2]),
    .cipher_key_i(key256), .busy_o(busy[2]), .ready_o(ready[2]), .keys_avail_o(avail[2]),
    .rd_index_i(rd_idx[2]), .rd_key_o(rdkey[2]));

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? 8'((a << 1) ^ 8'h1b) : 8'(a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key expansion as written in the standard's pseudocode; key is left-aligned in k
  task automatic build_ref(input int nk, input logic [255:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) ref_w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % 4 == 0) t = sub_word_m(t);
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_key(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  task automatic set_key(input int s, input logic [255:0] k);
    case (s)
      0: key128 = k[255:128];
      1: key192 = k[255:64];
      default: key256 = k;
    endcase
  endtask

  // One-cycle start pulse; returns at the falling edge right after E0
  task automatic kick(input int s, input logic [255:0] k);
    @(negedge clk);
    set_key(s, k);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  task automatic wait_ready(input int s, output int edges, output bit both);
    edges = 0;
    both  = 1'b0;
    while (!ready[s] && edges < 200) begin
      @(negedge clk);
      edges++;
      if (busy[s] && ready[s]) both = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      start[s] = 1'b0;
      rd_idx[s] = 4'd0;
    end
    key128 = '0; key192 = '0; key256 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_cmp += 3;
      if (busy[s] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy[s]); end
      if (ready[s] !== 1'b0) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 0", s, ready[s]); end
      if (avail[s] !== 4'd0) begin n_bad++; $display("FAIL reset_avail[%0d]: got %0d want 0", s, avail[s]); end
      for (int r = 0; r < 16; r++) begin
        rd_idx[s] = 4'(r);
        #1 n_cmp++;
        if (rdkey[s] !== 128'h0) begin n_bad++; $display("FAIL reset_rdkey[%0d][%0d]: got %h want 0", s, r, rdkey[s]); end
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b0 || avail[0] !== 4'd0) begin
      n_bad++; $display("FAIL idle_after_release: got busy=%b avail=%0d want 0/0", busy[0], avail[0]);
    end
  endtask

  task automatic test_kat128();
    build_ref(4, K2);
    kick(0, K2);
    n_cmp += 3;
    if (avail[0] !== 4'd1) begin n_bad++; $display("FAIL k128_avail_e0: got %0d want 1", avail[0]); end
    if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL k128_busy_e0: got %b want 1", busy[0]); end
    if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL k128_ready_e0: got %b want 0", ready[0]); end
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      n_cmp += 3;
      if (avail[0] !== 4'((4 + e) / 4)) begin n_bad++; $display("FAIL k128_avail_e%0d: got %0d want %0d", e, avail[0], (4 + e) / 4); end
      if (ready[0] !== (e >= 40)) begin n_bad++; $display("FAIL k128_ready_e%0d: got %b want %b", e, ready[0], e >= 40); end
      if (busy[0] !== (e < 40)) begin n_bad++; $display("FAIL k128_busy_e%0d: got %b want %b", e, busy[0], e < 40); end
    end
    rd_idx[0] = 4'd1;
    #1 n_cmp++;
    if (rdkey[0] !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_bad++; $display("FAIL k128_rk1: got %h want a0fafe1788542cb123a339392a6c7605", rdkey[0]); end
    rd_idx[0] = 4'd10;
    #1 n_cmp++;
    if (rdkey[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_bad++; $display("FAIL k128_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rdkey[0]); end
    for (int r = 0; r < 16; r++) begin
      rd_idx[0] = 4'(r);
      #1 n_cmp++;
      if (rdkey[0] !== (r <= 10 ? ref_key(r) : 128'h0)) begin
        n_bad++; $display("FAIL k128_table[%0d]: got %h want %h", r, rdkey[0], r <= 10 ? ref_key(r) : 128'h0);
      end
    end
  endtask

  task automatic test_kat256();
    int edges;
    bit both;
    build_ref(8, K3);
    kick(2, K3);
    n_cmp++;
    if (avail[2] !== 4'd2) begin n_bad++; $display("FAIL k256_avail_e0: got %0d want 2", avail[2]); end
    wait_ready(2, edges, both);
    n_cmp += 3;
    if (edges != 52) begin n_bad++; $display("FAIL k256_ready_edge: got %0d want 52", edges); end
    if (both) begin n_bad++; $display("FAIL k256_busy_and_ready: got 1 want 0"); end
    if (avail[2] !== 4'd15) begin n_bad++; $display("FAIL k256_avail_done: got %0d want 15", avail[2]); end
    rd_idx[2] = 4'd14;
    #1 n_cmp++;
    if (rdkey[2] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin n_bad++; $display("FAIL k256_rk14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", rdkey[2]); end
    for (int r = 0; r < 16; r++) begin
      rd_idx[2] = 4'(r);
      #1 n_cmp++;
      if (rdkey[2] !== (r <= 14 ? ref_key(r) : 128'h0)) begin
        n_bad++; $display("FAIL k256_table[%0d]: got %h want %h", r, rdkey[2], r <= 14 ? ref_key(r) : 128'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first_ready = -1, edges;
    bit both;
    build_ref(4, K2);
    kick(0, K2);
    for (int e = 1; e <= 45; e++) begin
      if (e == 10) begin
        set_key(0, {$urandom, $urandom, $urandom, $urandom, 128'h0});
        start[0] = 1'b1;
      end
      @(negedge clk);
      start[0] = 1'b0;
      if (ready[0] && first_ready < 0) first_ready = e;
    end
    n_cmp++;
    if (first_ready != 40) begin n_bad++; $display("FAIL busy_start_ready_edge: got %0d want 40", first_ready); end
    for (int r = 0; r <= 10; r++) begin
      rd_idx[0] = 4'(r);
      #1 n_cmp++;
      if (rdkey[0] !== ref_key(r)) begin n_bad++; $display("FAIL busy_start_table[%0d]: got %h want %h", r, rdkey[0], ref_key(r)); end
    end
    kick(0, 256'h0);
    n_cmp += 3;
    if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL rekey_busy: got %b want 1", busy[0]); end
    if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL rekey_ready: got %b want 0", ready[0]); end
    if (avail[0] !== 4'd1) begin n_bad++; $display("FAIL rekey_avail: got %0d want 1", avail[0]); end
    wait_ready(0, edges, both);
    n_cmp += 2;
    if (edges != 40) begin n_bad++; $display("FAIL rekey_ready_edge: got %0d want 40", edges); end
    if (both) begin n_bad++; $display("FAIL rekey_busy_and_ready: got 1 want 0"); end
    rd_idx[0] = 4'd10;
    #1 n_cmp++;
    if (rdkey[0] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin n_bad++; $display("FAIL rekey_rk10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", rdkey[0]); end
  endtask

  task automatic test_async_reset();
    int edges;
    bit both;
    rd_idx[0] = 4'd0;
    kick(0, K2);
    repeat (16) @(negedge clk);
    n_cmp++;
    if (avail[0] !== 4'd5 || busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_progress: got avail=%0d busy=%b want 5/1", avail[0], busy[0]);
    end
    #2 rst_n = 1'b0;
    #1 n_cmp += 4;
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL async_busy: got %b want 0", busy[0]); end
    if (ready[0] !== 1'b0) begin n_bad++; $display("FAIL async_ready: got %b want 0", ready[0]); end
    if (avail[0] !== 4'd0) begin n_bad++; $display("FAIL async_avail: got %0d want 0", avail[0]); end
    if (rdkey[0] !== 128'h0) begin n_bad++; $display("FAIL async_rdkey: got %h want 0", rdkey[0]); end
    @(negedge clk) rst_n = 1'b1;
    build_ref(4, K2);
    kick(0, K2);
    wait_ready(0, edges, both);
    n_cmp++;
    if (edges != 40) begin n_bad++; $display("FAIL post_reset_ready_edge: got %0d want 40", edges); end
    for (int r = 1; r <= 10; r += 9) begin
      rd_idx[0] = 4'(r);
      #1 n_cmp++;
      if (rdkey[0] !== ref_key(r)) begin n_bad++; $display("FAIL post_reset_rk%0d: got %h want %h", r, rdkey[0], ref_key(r)); end
    end
  endtask

  task automatic test_random();
    int edges, nk;
    bit both;
    logic [255:0] k;
    for (int s = 0; s < 3; s++) begin
      nk = 4 + 2 * s;
      for (int n = 0; n < 3; n++) begin
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (nk == 4) k[127:0] = '0;
        if (nk == 6) k[63:0] = '0;
        build_ref(nk, k);
        kick(s, k);
        wait_ready(s, edges, both);
        n_cmp += 2;
        if (edges != 4 * (nk + 7) - nk) begin n_bad++; $display("FAIL rand_ready_edge[%0d]: got %0d want %0d", s, edges, 4 * (nk + 7) - nk); end
        if (both) begin n_bad++; $display("FAIL rand_busy_and_ready[%0d]: got 1 want 0", s); end
        for (int r = 0; r <= nk + 6; r++) begin
          rd_idx[s] = 4'(r);
          #1 n_cmp++;
          if (rdkey[s] !== ref_key(r)) begin n_bad++; $display("FAIL rand_table[%0d][%0d]: got %h want %h", s, r, rdkey[s], ref_key(r)); end
        end
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_kat128();
    test_kat256();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
